// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampled UART receiver and its FIFO.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Tick counter wide enough for OVERSAMPLE up to 256; bit counter covers up to 9 data bits.
    localparam int TICK_W = 8;
    localparam int BIT_W  = 4;

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic par(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head word reads as zero while empty.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = fifo_cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the head slot on the same edge, so a full FIFO still accepts a push.
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with optional parity, sticky error flags and a receive FIFO.
// state  | meaning
// IDLE   | line idle, waiting for a low rx_s while enabled
// START  | confirming start bit at its centre
// DATA   | sampling data bits LSB first at bit centres
// PARITY | checking the parity bit
// STOP   | checking the stop bit, pushing the word when it is high
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 rxclk,
    input  logic                 reset,
    input  logic                 rxen,
    input  logic                 rxin,
    input  logic                 rxuld,
    output logic [DATA_BITS-1:0] rxrcvd,
    output logic                 rxempty,
    output logic                 rxfull,
    output logic                 overrun,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam logic [TICK_W-1:0] HALF_TC  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_TC  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic              ODD      = (PARITY_ODD != 0);

    rx_state_t            state_q, state_d;
    logic                 sync1_q, rx_s_q;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 ovr_q, ovr_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 push;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q + 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        push    = 1'b0;
        if (!rxen) begin
            state_d = IDLE;
            tick_d  = '0;
            bit_d   = '0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tick_d = '0;
                    bit_d  = '0;
                    if (!rx_s_q) state_d = START;
                end
                START: if (tick_q == HALF_TC) begin
                    tick_d  = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end
                DATA: if (tick_q == FULL_TC) begin
                    tick_d  = '0;
                    shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
                PARITY: if (tick_q == FULL_TC) begin
                    tick_d  = '0;
                    state_d = STOP;
                    if (rx_s_q != par(9'(shreg_q), ODD)) perr_d = 1'b1;
                end
                STOP: if (tick_q == FULL_TC) begin
                    tick_d  = '0;
                    state_d = IDLE;
                    if (rx_s_q) push   = 1'b1;
                    else        ferr_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
        ovr_d = rxen && (ovr_q || (push && rxfull && !rxuld));
    end

    always_ff @(posedge rxclk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            sync1_q <= rxin;
            rx_s_q  <= sync1_q;
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (rxclk),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (rxuld),
        .din_i   (shreg_q),
        .dout_o  (rxrcvd),
        .empty_o (rxempty),
        .full_o  (rxfull)
    );

    assign overrun    = ovr_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized checks of two receiver instances (8N1 and 8E1) against a queue model.
module tb_uart_rx_fifo;

    logic       rxclk;
    logic       reset;
    logic       rxen;
    logic       rxin0, rxin1;
    logic       uld0, uld1;
    logic [7:0] rcvd0, rcvd1;
    logic       empty0, empty1, full0, full1;
    logic       ovr0, ovr1, fer0, fer1, per0, per1;

    int n_cmp = 0;
    int n_err = 0;

    int q0[$];
    int q1[$];
    bit ov[2];
    bit fe[2];
    bit pe[2];

    int         w, np;
    logic [7:0] d;
    logic       pb, sb;

    uart_rx_fifo #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(4)
    ) u_dut0 (
        .rxclk(rxclk), .reset(reset), .rxen(rxen), .rxin(rxin0), .rxuld(uld0),
        .rxrcvd(rcvd0), .rxempty(empty0), .rxfull(full0), .overrun(ovr0),
        .frame_err(fer0), .parity_err(per0)
    );

    uart_rx_fifo #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(4)
    ) u_dut1 (
        .rxclk(rxclk), .reset(reset), .rxen(rxen), .rxin(rxin1), .rxuld(uld1),
        .rxrcvd(rcvd1), .rxempty(empty1), .rxfull(full1), .overrun(ovr1),
        .frame_err(fer1), .parity_err(per1)
    );

    initial rxclk = 1'b0;
    always #5 rxclk = ~rxclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int which);
        logic [7:0] rc;
        logic       em, fu, o, f, p;
        int         sz;
        int         exp_rc;
        if (which == 0) begin
            rc = rcvd0; em = empty0; fu = full0; o = ovr0; f = fer0; p = per0;
            sz = q0.size();
            exp_rc = (sz > 0) ? q0[0] : 0;
        end else begin
            rc = rcvd1; em = empty1; fu = full1; o = ovr1; f = fer1; p = per1;
            sz = q1.size();
            exp_rc = (sz > 0) ? q1[0] : 0;
        end
        check($sformatf("d%0d_rxrcvd", which),     32'(rc), 32'(exp_rc));
        check($sformatf("d%0d_rxempty", which),    32'(em), 32'(sz == 0));
        check($sformatf("d%0d_rxfull", which),     32'(fu), 32'(sz == 4));
        check($sformatf("d%0d_overrun", which),    32'(o),  32'(ov[which]));
        check($sformatf("d%0d_frame_err", which),  32'(f),  32'(fe[which]));
        check($sformatf("d%0d_parity_err", which), 32'(p),  32'(pe[which]));
    endtask

    task automatic model_push(input int which, input int data);
        if (which == 0) begin
            if (q0.size() < 4) q0.push_back(data);
            else ov[0] = 1'b1;
        end else begin
            if (q1.size() < 4) q1.push_back(data);
            else ov[1] = 1'b1;
        end
    endtask

    task automatic model_pop(input int which);
        if (which == 0) begin
            if (q0.size() > 0) void'(q0.pop_front());
        end else begin
            if (q1.size() > 0) void'(q1.pop_front());
        end
    endtask

    task automatic model_frame(input int which, input logic [7:0] data,
                               input logic pbit, input logic stop);
        if (which == 1 && pbit != 1'($countones(data) % 2)) pe[1] = 1'b1;
        if (!stop) fe[which] = 1'b1;
        else       model_push(which, int'(data));
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            ov[i] = 1'b0; fe[i] = 1'b0; pe[i] = 1'b0;
        end
    endtask

    function automatic logic [15:0] mk(input int which, input logic [7:0] data,
                                       input logic pbit, input logic stop);
        logic [15:0] v;
        v = '1;
        v[0] = 1'b0;
        v[8:1] = data;
        if (which == 0) v[9] = stop;
        else begin
            v[9]  = pbit;
            v[10] = stop;
        end
        return v;
    endfunction

    // Drives n bit periods of vec LSB first; called and returns 1 time unit after a rising edge.
    task automatic send(input int which, input logic [15:0] vec, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) rxin0 = vec[i];
            else            rxin1 = vec[i];
            repeat (16) @(posedge rxclk);
            #1;
        end
        rxin0 = 1'b1;
        rxin1 = 1'b1;
    endtask

    task automatic send_frame(input int which, input logic [7:0] data,
                              input logic pbit, input logic stop);
        send(which, mk(which, data, pbit, stop), (which == 0) ? 10 : 11);
        repeat (24) @(posedge rxclk);
        #1;
        model_frame(which, data, pbit, stop);
    endtask

    task automatic pop_n(input int which, input int n);
        if (which == 0) uld0 = 1'b1;
        else            uld1 = 1'b1;
        repeat (n) @(posedge rxclk);
        #1;
        uld0 = 1'b0;
        uld1 = 1'b0;
        for (int i = 0; i < n; i++) model_pop(which);
    endtask

    task automatic rxen_pulse();
        rxen = 1'b0;
        @(posedge rxclk);
        #1;
        rxen = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ov[i] = 1'b0; fe[i] = 1'b0; pe[i] = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; rxen = 1'b0;
        rxin0 = 1'b1; rxin1 = 1'b1;
        uld0 = 1'b0;  uld1 = 1'b0;
        model_clear();
        repeat (3) @(posedge rxclk);
        #1;
        reset = 1'b0;
        check_dut(0);
        check_dut(1);
        rxen = 1'b1;
        repeat (4) @(posedge rxclk);
        #1;

        // Single 0x55 frame: word appears just after the stop-bit centre.
        send(0, mk(0, 8'h55, 1'b0, 1'b1), 9);
        repeat (6) @(posedge rxclk);
        #1;
        check("d0_empty_before_stop_centre", 32'(empty0), 32'd1);
        repeat (7) @(posedge rxclk);
        #1;
        model_push(0, 8'h55);
        check_dut(0);
        repeat (24) @(posedge rxclk);
        #1;
        pop_n(0, 1);
        check_dut(0);

        // Short start glitch is ignored, then a valid frame.
        rxin0 = 1'b0;
        repeat (4) @(posedge rxclk);
        #1;
        rxin0 = 1'b1;
        repeat (30) @(posedge rxclk);
        #1;
        check_dut(0);
        send_frame(0, 8'hA3, 1'b0, 1'b1);
        check_dut(0);
        pop_n(0, 1);
        check_dut(0);

        // Bad stop bit, then rxen drop clears the flag.
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        check_dut(0);
        rxen_pulse();
        check_dut(0);

        // Overflow with five frames, contents survive an rxen drop, in-order drain.
        for (int i = 1; i <= 5; i++) begin
            send_frame(0, 8'(i), 1'b0, 1'b1);
            check_dut(0);
        end
        rxen_pulse();
        check_dut(0);
        for (int i = 0; i < 4; i++) begin
            pop_n(0, 1);
            check_dut(0);
        end
        pop_n(0, 1);
        check_dut(0);

        // Full FIFO: push coincides with a pop, no overrun.
        for (int i = 0; i < 4; i++) send_frame(0, 8'(8'h11 + i), 1'b0, 1'b1);
        check_dut(0);
        fork
            send(0, mk(0, 8'h15, 1'b0, 1'b1), 10);
            begin
                repeat (154) @(posedge rxclk);
                #1;
                uld0 = 1'b1;
                @(posedge rxclk);
                #1;
                uld0 = 1'b0;
            end
        join
        model_pop(0);
        model_push(0, 8'h15);
        repeat (24) @(posedge rxclk);
        #1;
        check_dut(0);
        for (int i = 0; i < 4; i++) begin
            pop_n(0, 1);
            check_dut(0);
        end

        // Even parity: bad parity flags but keeps the word; good parity keeps the flag.
        send_frame(1, 8'h07, 1'b0, 1'b1);
        check_dut(1);
        send_frame(1, 8'h07, 1'b1, 1'b1);
        check_dut(1);
        pop_n(1, 1);
        check_dut(1);
        pop_n(1, 1);
        check_dut(1);

        // Reset during data bits drops the partial frame and the FIFO contents.
        send_frame(0, 8'h42, 1'b0, 1'b1);
        check_dut(0);
        send(0, mk(0, 8'h9E, 1'b0, 1'b1), 4);
        reset = 1'b1;
        repeat (2) @(posedge rxclk);
        #1;
        reset = 1'b0;
        model_clear();
        repeat (5) @(posedge rxclk);
        #1;
        check_dut(0);
        check_dut(1);
        send_frame(0, 8'h9E, 1'b0, 1'b1);
        check_dut(0);
        pop_n(0, 1);
        check_dut(0);

        // Randomized frames on both instances with random unloads.
        rxen_pulse();
        for (int i = 0; i < 16; i++) begin
            w  = int'($urandom_range(0, 1));
            d  = 8'($urandom_range(0, 255));
            sb = ($urandom_range(0, 5) != 0);
            pb = 1'($urandom_range(0, 1));
            send_frame(w, d, pb, sb);
            check_dut(w);
            np = int'($urandom_range(0, 2));
            if (np > 0) begin
                pop_n(w, np);
                check_dut(w);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
